output_port: RTL and testbench

- Memory-mapped output peripheral on the shared tri-state system bus.
- CPU writes to a hard-wired data address and each word is queued in a small FIFO.
- A downstream consumer (LED/display/serial driver) drains the FIFO over a valid/ready handshake.
- A hard-wired status address returns FIFO occupancy and overflow flags on CPU reads.

---
 rtl/output_port_pkg.sv | 20 ++
 rtl/output_port_fifo.sv | 62 ++++++
 rtl/output_port.sv | 101 ++++++++++
 tb/tb_output_port.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/output_port_pkg.sv
// Shared constants for the output_port peripheral: default bus addresses,
// status-word bit layout and a constant log2 helper for sizing counters.
package output_port_pkg;

    localparam int OUT_ADDR_DEF  = 127;
    localparam int STAT_ADDR_DEF = 125;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/output_port_fifo.sv
// Small synchronous FIFO holding words queued by the CPU until the downstream
// consumer takes them; head word reads as zero whenever the FIFO is empty.
module port_fifo
    import output_port_pkg::*;
#(
    parameter  int WORD_W = 10,
    parameter  int DEPTH  = 4,
    localparam int PW     = clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata,
    output logic [CW-1:0]     o_count,
    output logic              o_empty,
    output logic              o_full
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO can still take a word when the head leaves on the same edge.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clock) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset, so mask the head until something is queued.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/output_port.sv
// Memory-mapped output port: CPU writes to OUT_ADDR are queued for a
// valid/ready consumer; reads of STAT_ADDR return occupancy and a sticky overflow.
module output_port
    import output_port_pkg::*;
#(
    parameter int WORD_W    = 10,
    parameter int OP_W      = 3,
    parameter int OUT_ADDR  = OUT_ADDR_DEF,
    parameter int STAT_ADDR = STAT_ADDR_DEF,
    parameter int DEPTH     = 4
) (
    input  logic              clock,
    input  logic              n_reset,
    inout  wire  [WORD_W-1:0] sysbus,
    input  logic              load_MAR,
    input  logic              load_MDR,
    input  logic              MDR_bus,
    input  logic              R_NW,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
);

    localparam int AW = WORD_W - OP_W;
    localparam int CW = clog2(DEPTH) + 1;

    if (OUT_ADDR >= (1 << AW)) begin : g_bad_out_addr
        $error("OUT_ADDR does not fit in the address field");
    end
    if (STAT_ADDR == OUT_ADDR) begin : g_bad_stat_addr
        $error("STAT_ADDR must differ from OUT_ADDR");
    end
    if (DEPTH < 2 || (1 << clog2(DEPTH)) != DEPTH) begin : g_bad_depth
        $error("DEPTH must be a power of two, at least 2");
    end
    if (ST_CNT_LSB + CW > WORD_W) begin : g_bad_width
        $error("status word does not fit on the bus");
    end

    logic [AW-1:0]     r_mar;
    logic              r_overflow;
    logic              w_wr_hit;
    logic              w_rd_hit;
    logic              w_pop;
    logic              w_push;
    logic              w_empty;
    logic              w_full;
    logic [CW-1:0]     w_count;
    logic [WORD_W-1:0] w_status;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset)
            r_mar <= '0;
        else if (load_MAR)
            r_mar <= sysbus[AW-1:0];
    end

    assign w_wr_hit = load_MDR & ~R_NW & (r_mar == AW'(OUT_ADDR));
    assign w_rd_hit = MDR_bus  &  R_NW & (r_mar == AW'(STAT_ADDR));
    assign w_pop    = out_valid & out_ready;
    assign w_push   = w_wr_hit & (~w_full | w_pop);

    // Read-to-clear, but a write dropped on the same edge keeps the flag set.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset)
            r_overflow <= 1'b0;
        else if (w_wr_hit && !w_push)
            r_overflow <= 1'b1;
        else if (w_rd_hit)
            r_overflow <= 1'b0;
    end

    port_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .n_reset (n_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (sysbus),
        .o_rdata (out_data),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_comb begin
        w_status                     = '0;
        w_status[ST_EMPTY]           = w_empty;
        w_status[ST_FULL]            = w_full;
        w_status[ST_OVF]             = r_overflow;
        w_status[ST_CNT_LSB +: CW]   = w_count;
    end

    assign sysbus    = w_rd_hit ? w_status : 'z;
    assign out_valid = ~w_empty;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_output_port.sv
// Scoreboard bench for output_port: accepted writes are queued by a model and
// compared as the consumer drains them; status reads are checked against the model.
module tb_output_port;

    localparam int WORD_W = 10;
    localparam int DEPTH  = 4;
    localparam int OUT_A  = 127;
    localparam int STAT_A = 125;
    localparam logic [WORD_W-1:0] FLOAT = '1;

    logic              clock = 1'b0;
    logic              n_reset;
    tri1 [WORD_W-1:0]  sysbus;
    logic              load_MAR, load_MDR, MDR_bus, R_NW, out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_valid, overflow;

    logic              r_drv_en;
    logic [WORD_W-1:0] r_drv;

    int                n_tests = 0;
    int                n_fail  = 0;

    logic [WORD_W-1:0] q [$];
    int                m_mar;
    logic              m_ovf;
    logic              pend_vld, pend_ovf, pend_clr;
    logic [WORD_W-1:0] pend_word;

    assign sysbus = r_drv_en ? r_drv : 'z;

    always #5 clock = ~clock;

    output_port dut (
        .clock     (clock),
        .n_reset   (n_reset),
        .sysbus    (sysbus),
        .load_MAR  (load_MAR),
        .load_MDR  (load_MDR),
        .MDR_bus   (MDR_bus),
        .R_NW      (R_NW),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] exp_status();
        logic [WORD_W-1:0] s;
        s      = '0;
        s[0]   = (q.size() == 0);
        s[1]   = (q.size() == DEPTH);
        s[2]   = m_ovf;
        s[5:3] = 3'(q.size());
        return s;
    endfunction

    // Called just after a negedge with inputs set; checks, crosses one rising edge,
    // then applies the model's pending updates.
    task automatic tick();
        logic [WORD_W-1:0] head;
        chk("valid", out_valid, q.size() != 0);
        chk("overflow", overflow, m_ovf);
        if (q.size() != 0 && out_ready) begin
            head = q.pop_front();
            chk("drain", out_data, head);
        end
        @(posedge clock);
        if (pend_vld) q.push_back(pend_word);
        if (pend_ovf) m_ovf = 1'b1;
        else if (pend_clr) m_ovf = 1'b0;
        pend_vld = 0; pend_ovf = 0; pend_clr = 0;
        @(negedge clock);
    endtask

    task automatic set_mar(input int a);
        r_drv_en = 1; r_drv = WORD_W'(a); load_MAR = 1;
        tick();
        load_MAR = 0; r_drv_en = 0;
        m_mar = a;
    endtask

    task automatic bus_write(input logic [WORD_W-1:0] d);
        r_drv_en = 1; r_drv = d; load_MDR = 1; R_NW = 0;
        if (m_mar == OUT_A) begin
            if (q.size() < DEPTH || (q.size() != 0 && out_ready)) begin
                pend_vld = 1; pend_word = d;
            end else
                pend_ovf = 1;
        end
        tick();
        load_MDR = 0; r_drv_en = 0;
    endtask

    task automatic stat_read();
        R_NW = 1; MDR_bus = 1;
        #1;
        if (m_mar == STAT_A) begin
            chk("status", sysbus, exp_status());
            pend_clr = 1;
        end else
            chk("float", sysbus, FLOAT);
        tick();
        R_NW = 0; MDR_bus = 0;
    endtask

    initial begin
        n_reset = 0; load_MAR = 0; load_MDR = 0; MDR_bus = 0; R_NW = 0; out_ready = 0;
        r_drv_en = 0; r_drv = '0;
        m_mar = 0; m_ovf = 0; pend_vld = 0; pend_ovf = 0; pend_clr = 0; pend_word = '0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clock); n_reset = 1;
        @(negedge clock);

        // Reset with three words queued
        set_mar(OUT_A);
        bus_write(10'h011); bus_write(10'h022); bus_write(10'h033);
        chk("pre_rst_valid", out_valid, 1);
        n_reset = 0; #1;
        q.delete(); m_mar = 0; m_ovf = 0;
        chk("rst3_valid", out_valid, 0);
        chk("rst3_ovf", overflow, 0);
        chk("rst3_bus", sysbus, FLOAT);
        @(negedge clock); n_reset = 1;
        @(negedge clock);
        set_mar(STAT_A);
        stat_read();

        // Single write, head visible after the edge
        set_mar(OUT_A);
        bus_write(10'h2A5);
        chk("head_2a5", out_data, 10'h2A5);
        set_mar(STAT_A);
        stat_read();
        out_ready = 1; tick(); out_ready = 0;

        // Overflow on fifth write, then read-to-clear
        set_mar(OUT_A);
        for (int i = 1; i <= 5; i++) bus_write(WORD_W'(i));
        set_mar(STAT_A);
        stat_read();
        stat_read();

        // Full plus simultaneous pop accepts the write
        set_mar(OUT_A);
        out_ready = 1;
        bus_write(10'h3FF);
        out_ready = 0;
        set_mar(STAT_A);
        stat_read();
        out_ready = 1;
        repeat (5) tick();
        out_ready = 0;

        // Bus discipline: non-status reads float, status writes ignored
        set_mar(126);
        stat_read();
        set_mar(OUT_A);
        stat_read();
        set_mar(STAT_A);
        bus_write(10'h0AA);
        stat_read();

        // Async reset mid-drain
        set_mar(OUT_A);
        bus_write(10'h100); bus_write(10'h101); bus_write(10'h102);
        out_ready = 1;
        tick();
        #2 n_reset = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_ovf", overflow, 0);
        q.delete(); m_mar = 0; m_ovf = 0;
        out_ready = 0;
        @(negedge clock); n_reset = 1;
        @(negedge clock);
        set_mar(OUT_A);
        bus_write(10'h155);
        chk("head_155", out_data, 10'h155);
        out_ready = 1;
        tick();
        tick();
        out_ready = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
